// File: rtl/sockit_spi_pkg.sv
// Shared types for the SPI command arbiter: requester ids and arbiter FSM states.
package sockit_spi_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    REG  = 2'b01,
    XIP  = 2'b10
  } own_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GNT_REG = 2'b01,
    GNT_XIP = 2'b10
  } arb_state_t;

  // Requester that owns the command stream in a given arbiter state.
  function automatic own_t state_own(input arb_state_t s);
    own_t o;
    unique case (s)
      GNT_REG: o = REG;
      GNT_XIP: o = XIP;
      default: o = NONE;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sockit_spi_fifo_own.sv
// Ownership FIFO: remembers, in issue order, which requester each response packet belongs to.
module sockit_spi_fifo_own
  import sockit_spi_pkg::*;
#(
  parameter int unsigned OFD = 4,
  localparam int unsigned OFA = $clog2(OFD)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  own_t         push_id,
  input  logic         pop,
  output own_t         head_c,
  output logic         full,
  output logic         empty,
  output logic [OFA:0] cnt
);

  own_t           mem [OFD];
  logic [OFA-1:0] wr_ptr;
  logic [OFA-1:0] rd_ptr;
  logic           do_push;
  logic           do_pop;
  logic [OFA:0]   cnt_nxt;

  // Guard against overflow/underflow and compute the next occupancy.
  always_comb begin
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    cnt_nxt = cnt;
    if (do_push && !do_pop) begin
      cnt_nxt = cnt + (OFA+1)'(1);
    end else if (do_pop && !do_push) begin
      cnt_nxt = cnt - (OFA+1)'(1);
    end
  end

  // Storage, wrapping pointers and registered occupancy flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < OFD; i++) begin
        mem[i] <= NONE;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_id;
        wr_ptr      <= wr_ptr + OFA'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + OFA'(1);
      end
      cnt   <= cnt_nxt;
      full  <= (cnt_nxt == (OFA+1)'(OFD));
      empty <= (cnt_nxt == '0);
    end
  end

  assign head_c = mem[rd_ptr];

endmodule

// File: rtl/sockit_spi_cmd_arb.sv
// Packet-level arbiter sharing the SPI serializer between REG and XIP, with in-order response routing.
module sockit_spi_cmd_arb
  import sockit_spi_pkg::*;
#(
  parameter int unsigned CDW = 32,
  parameter int unsigned RDW = 32,
  parameter int unsigned OFD = 4,
  localparam int unsigned OFA = $clog2(OFD)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_pri,
  input  logic           reg_cmd_vld,
  input  logic           reg_cmd_lst,
  input  logic           reg_cmd_rsp,
  input  logic [CDW-1:0] reg_cmd_dat,
  output logic           reg_cmd_rdy,
  input  logic           xip_cmd_vld,
  input  logic           xip_cmd_lst,
  input  logic           xip_cmd_rsp,
  input  logic [CDW-1:0] xip_cmd_dat,
  output logic           xip_cmd_rdy,
  output logic           ser_cmd_vld,
  output logic           ser_cmd_lst,
  output logic [CDW-1:0] ser_cmd_dat,
  input  logic           ser_cmd_rdy,
  input  logic           ser_dat_vld,
  input  logic           ser_dat_lst,
  input  logic [RDW-1:0] ser_dat_dat,
  output logic           ser_dat_rdy,
  output logic           reg_dat_vld,
  output logic           reg_dat_lst,
  output logic [RDW-1:0] reg_dat_dat,
  input  logic           reg_dat_rdy,
  output logic           xip_dat_vld,
  output logic           xip_dat_lst,
  output logic [RDW-1:0] xip_dat_dat,
  input  logic           xip_dat_rdy,
  output logic [1:0]     sts_own,
  output logic [OFA:0]   sts_cnt,
  output logic           sts_err,
  input  logic           sts_clr
);

  arb_state_t state, state_nxt;
  logic       pref_xip;
  logic       first_q;
  logic       reg_elig, xip_elig;
  logic       cmd_hs, cmd_lst, cmd_rsp;
  own_t       cmd_own;
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  own_t       fifo_head;
  logic       orphan;

  // Arbitration and command-stream multiplexing.
  always_comb begin
    state_nxt   = state;
    ser_cmd_vld = 1'b0;
    ser_cmd_lst = 1'b0;
    ser_cmd_dat = '0;
    reg_cmd_rdy = 1'b0;
    xip_cmd_rdy = 1'b0;
    cmd_hs      = 1'b0;
    cmd_lst     = 1'b0;
    cmd_rsp     = 1'b0;
    cmd_own     = NONE;
    reg_elig    = reg_cmd_vld & (~reg_cmd_rsp | ~fifo_full);
    xip_elig    = xip_cmd_vld & (~xip_cmd_rsp | ~fifo_full);
    unique case (state)
      IDLE: begin
        if (reg_elig && xip_elig) begin
          state_nxt = (cfg_pri || pref_xip) ? GNT_XIP : GNT_REG;
        end else if (reg_elig) begin
          state_nxt = GNT_REG;
        end else if (xip_elig) begin
          state_nxt = GNT_XIP;
        end
      end
      GNT_REG: begin
        ser_cmd_vld = reg_cmd_vld;
        ser_cmd_lst = reg_cmd_lst;
        ser_cmd_dat = reg_cmd_dat;
        reg_cmd_rdy = ser_cmd_rdy;
        cmd_hs      = reg_cmd_vld & ser_cmd_rdy;
        cmd_lst     = reg_cmd_lst;
        cmd_rsp     = reg_cmd_rsp;
        cmd_own     = REG;
        if (cmd_hs && cmd_lst) state_nxt = IDLE;
      end
      GNT_XIP: begin
        ser_cmd_vld = xip_cmd_vld;
        ser_cmd_lst = xip_cmd_lst;
        ser_cmd_dat = xip_cmd_dat;
        xip_cmd_rdy = ser_cmd_rdy;
        cmd_hs      = xip_cmd_vld & ser_cmd_rdy;
        cmd_lst     = xip_cmd_lst;
        cmd_rsp     = xip_cmd_rsp;
        cmd_own     = XIP;
        if (cmd_hs && cmd_lst) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fifo_push = cmd_hs & first_q & cmd_rsp;

  // Arbiter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Round-robin pointer: after a packet completes, prefer the other requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   pref_xip <= 1'b0;
    else if (cmd_hs && cmd_lst) pref_xip <= (state == GNT_REG);
  end

  // First-word marker so each packet pushes at most one owner id.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     first_q <= 1'b1;
    else if (state_nxt == IDLE)  first_q <= 1'b1;
    else if (cmd_hs)             first_q <= 1'b0;
  end

  // Status: current grant and sticky orphan flag (set wins over clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sts_own <= NONE;
      sts_err <= 1'b0;
    end else begin
      sts_own <= state_own(state_nxt);
      if (orphan)       sts_err <= 1'b1;
      else if (sts_clr) sts_err <= 1'b0;
    end
  end

  sockit_spi_fifo_own #(.OFD(OFD)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .push_id (cmd_own),
    .pop     (fifo_pop),
    .head_c  (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .cnt     (sts_cnt)
  );

  // Response routing to the head owner; responses with no owner are drained.
  always_comb begin
    ser_dat_rdy = 1'b0;
    reg_dat_vld = 1'b0;
    xip_dat_vld = 1'b0;
    orphan      = 1'b0;
    if (fifo_empty) begin
      orphan      = ser_dat_vld & ~rst;
      ser_dat_rdy = orphan;
    end else if (fifo_head == XIP) begin
      xip_dat_vld = ser_dat_vld;
      ser_dat_rdy = xip_dat_rdy;
    end else begin
      reg_dat_vld = ser_dat_vld;
      ser_dat_rdy = reg_dat_rdy;
    end
    fifo_pop = ~fifo_empty & ser_dat_vld & ser_dat_rdy & ser_dat_lst;
  end

  assign reg_dat_lst = ser_dat_lst;
  assign reg_dat_dat = ser_dat_dat;
  assign xip_dat_lst = ser_dat_lst;
  assign xip_dat_dat = ser_dat_dat;

endmodule

// File: doc/sockit_spi_cmd_arb.md
Name: sockit_spi_cmd_arb

Overview:
Packet-level arbiter sharing the single SPI serializer command stream between two requesters: the register command writer (REG) and the XIP engine (XIP). Grants whole command packets (locked until the last word). Records, per issued packet that expects read data, which requester owns it, and routes the serializer's read-data packets back to that owner in order. Sits between sockit_spi_reg/XIP and the serializer.

Parameters:
CDW, 32, command word width
RDW, 32, read data word width
OFD, 4, ownership FIFO depth (power of 2, >=2)
OFA, $clog2(OFD), ownership FIFO pointer width (derived)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cfg_pri  in  1  0=round-robin, 1=XIP strict priority
reg_cmd_vld/lst/rsp/dat/rdy  in/in/in/in/out  1/1/1/CDW/1  REG command stream; rsp (valid with first word) = packet produces one response packet
xip_cmd_vld/lst/rsp/dat/rdy  in/in/in/in/out  1/1/1/CDW/1  XIP command stream, same rules
ser_cmd_vld/lst/dat/rdy  out/out/out/in  1/1/CDW/1  to serializer
ser_dat_vld/lst/dat/rdy  in/in/in/out  1/1/RDW/1  read data from serializer
reg_dat_vld/lst/dat/rdy  out/out/out/in  1/1/RDW/1  read data to REG
xip_dat_vld/lst/dat/rdy  out/out/out/in  1/1/RDW/1  read data to XIP
sts_own  out  2  current grant: 00 none, 01 REG, 10 XIP
sts_cnt  out  OFA+1  ownership FIFO occupancy
sts_err  out  1  sticky orphan-response flag
sts_clr  in  1  clears sts_err

Behaviour:
- Reset (async, rst=1): state IDLE, rr pointer = REG-preferred, FIFO empty, sts_own=00, sts_cnt=0, sts_err=0; all *_rdy and *_vld outputs 0.
- Handshake: a word transfers when vld&rdy in the same cycle. vld must not depend on rdy. Data/lst/rsp are held stable while vld=1 and rdy=0 (requester obligation; the bench checks it).
- Command FSM states: IDLE, GNT_REG, GNT_XIP.
- IDLE: candidate = requester with vld=1 and (rsp=0 or FIFO not full). With both eligible: cfg_pri=1 -> XIP; cfg_pri=0 -> the one not granted last. Grant is registered: the state moves next cycle; all cmd rdy=0 in IDLE (one bubble cycle per packet).
- GNT_x: ser_cmd_{vld,lst,dat} = x_cmd_{vld,lst,dat} combinationally; x_cmd_rdy = ser_cmd_rdy; the other requester's rdy=0.
- GNT_x: on the first-word handshake with rsp=1, push owner id x into the FIFO (once per packet).
- GNT_x: on the handshake with lst=1, return to IDLE and update the rr pointer. A single-word packet (first word has lst=1) pushes and releases in the same cycle.
- cfg_pri is sampled only in IDLE; changes mid-packet have no effect.
- Response routing: when the FIFO is non-empty, the head id selects the destination. ser_dat_rdy = dest_rdy; dest_vld = ser_dat_vld; the other dat_vld=0. Pop on the ser_dat handshake with lst=1. Concurrent push and pop in the same cycle: occupancy unchanged.
- FIFO empty and ser_dat_vld=1: orphan. ser_dat_rdy=1 (data discarded), sts_err set the next cycle.
- sts_err: set has priority over sts_clr in the same cycle.
- FIFO full: requesters whose rsp=1 are ineligible, so no overflow is possible. A pop in the same cycle frees space only for the next arbitration.
- Pointers wrap modulo OFD; occupancy counter range 0..OFD.
- Latency: command path 0 cycles after grant; response path 0 cycles (combinational mux); status updates 1 cycle after the event.

Decomposition:
- sockit_spi_pkg additions: typedef own_t (enum NONE=2'b00, REG=2'b01, XIP=2'b10); typedef arb_state_t (IDLE, GNT_REG, GNT_XIP).
- One sub-module: sockit_spi_fifo_own, a synchronous FIFO of own_t, depth OFD, with push/pop/full/empty/cnt and async active-high reset.

Test Plan:
- Reset mid-packet: assert rst during word 2 of a 4-word REG packet -> all rdy/vld 0 immediately, sts_own=00, sts_cnt=0; after release a new packet is arbitrated normally.
- Round-robin: cfg_pri=0, both requesters continuously hold 2-word packets with rsp=0 -> ser_cmd sees REG, XIP, REG, XIP, each preceded by exactly one bubble cycle.
- Strict priority: cfg_pri=1, both valid -> XIP is granted every time; REG is granted only when xip_cmd_vld=0 in IDLE.
- Ordered routing: REG rsp packet, then XIP rsp packet; serializer returns two 3-word packets -> the first goes to reg_dat, the second to xip_dat; sts_cnt goes 1,2,1,0.
- FIFO full: OFD=4, issue 4 rsp packets with no responses, REG holds a 5th rsp=1 packet while XIP offers a rsp=0 packet -> XIP is granted, REG stalls; after one response lst handshake, REG is granted.
- Orphan response: FIFO empty, ser_dat_vld=1 for 1 word with lst=1 -> ser_dat_rdy=1, no dat_vld asserted, sts_err=1 the next cycle; sts_clr -> 0.
